// File: rtl/crc_checker.sv
// ============================================================================
//  Module   : crc_checker
//  Purpose  : Receive-side serial CRC checker. Rebuilds the LFSR over an
//             LSB-first serial message (DATA while Active), then compares the
//             CRC_WD CRC bits that follow (DATA while CRC_Valid). Emits a
//             one-cycle Done with a Pass verdict, or Done+Error on abort.
//  Ports    : CLK        in   clock, rising edge
//             RST        in   synchronous active-high reset
//             DATA       in   serial message / CRC bit
//             Active     in   qualifies message bits
//             CRC_Valid  in   qualifies CRC bits (gaps allowed)
//             Done       out  one-cycle verdict pulse
//             Pass       out  verdict, held until next Done
//             Error      out  abort pulse, only together with Done
//             Syndrome   out  [CRC_WD-1:0] received^computed CRC, held until
//                             next Done (only when CRC_CHK_SYNDROME_EN defined)
//  Config   : CRC_CHK_SYNDROME_EN adds the Syndrome output and its registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_checker #(
  parameter int                CRC_WD = 8,
  parameter logic [CRC_WD-1:0] POLY   = 8'h44,
  parameter logic [CRC_WD-1:0] SEED   = 8'hD8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DATA,
  input  logic              Active,
  input  logic              CRC_Valid,
  output logic              Done,
  output logic              Pass,
  output logic              Error
`ifdef CRC_CHK_SYNDROME_EN
  ,
  output logic [CRC_WD-1:0] Syndrome
`endif
);

  localparam int CNT_W = $clog2(CRC_WD + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CHECK  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CRC_WD-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mismatch_q, mismatch_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                error_q, error_d;
  logic                bit_err;
`ifdef CRC_CHK_SYNDROME_EN
  logic [CRC_WD-1:0]   syn_work_q, syn_work_d;
  logic [CRC_WD-1:0]   syn_q, syn_d;
`endif

  // One Galois LFSR step: feedback enters at the top and is XORed into every
  // lower bit whose POLY tap is set as the register shifts right.
  function automatic logic [CRC_WD-1:0] lfsr_step(input logic [CRC_WD-1:0] r,
                                                   input logic d);
    logic                fb;
    logic [CRC_WD-1:0]   nxt;
    fb = d ^ r[0];
    for (int i = 0; i < CRC_WD - 1; i++) begin
      nxt[i] = POLY[i] ? (r[i+1] ^ fb) : r[i+1];
    end
    nxt[CRC_WD-1] = fb;
    return nxt;
  endfunction

  // In CHECK the frozen LFSR is shifted out LSB first, so lfsr_q[0] is always
  // the expected CRC bit for the current position.
  assign bit_err = DATA ^ lfsr_q[0];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    pass_d     = pass_q;
`ifdef CRC_CHK_SYNDROME_EN
    syn_work_d = syn_work_q;
    syn_d      = syn_q;
`endif
    case (state_q)
      S_IDLE: begin
        lfsr_d = SEED;
        if (Active) begin
          lfsr_d  = lfsr_step(SEED, DATA);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (Active) begin
          lfsr_d = lfsr_step(lfsr_q, DATA);
        end else begin
          state_d    = S_CHECK;
          cnt_d      = '0;
          mismatch_d = 1'b0;
`ifdef CRC_CHK_SYNDROME_EN
          syn_work_d = '0;
`endif
        end
      end
      S_CHECK: begin
        if (Active) begin
          // Abort takes priority over a simultaneous CRC bit.
          done_d  = 1'b1;
          error_d = 1'b1;
          pass_d  = 1'b0;
          lfsr_d  = SEED;
          state_d = S_IDLE;
`ifdef CRC_CHK_SYNDROME_EN
          syn_d   = '0;
`endif
        end else if (CRC_Valid) begin
          mismatch_d = mismatch_q | bit_err;
          lfsr_d     = lfsr_q >> 1;
          cnt_d      = cnt_q + CNT_W'(1);
`ifdef CRC_CHK_SYNDROME_EN
          syn_work_d = {bit_err, syn_work_q[CRC_WD-1:1]};
`endif
          if (cnt_q == CNT_W'(CRC_WD - 1)) begin
            done_d  = 1'b1;
            pass_d  = ~(mismatch_q | bit_err);
            state_d = S_REPORT;
`ifdef CRC_CHK_SYNDROME_EN
            syn_d   = {bit_err, syn_work_q[CRC_WD-1:1]};
`endif
          end
        end
      end
      S_REPORT: begin
        // Done is high during this state; Active is deliberately ignored.
        lfsr_d  = SEED;
        state_d = S_IDLE;
      end
      default: begin
        lfsr_d  = SEED;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef CRC_CHK_SYNDROME_EN
      syn_work_q <= '0;
      syn_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      error_q    <= error_d;
`ifdef CRC_CHK_SYNDROME_EN
      syn_work_q <= syn_work_d;
      syn_q      <= syn_d;
`endif
    end
  end

  assign Done  = done_q;
  assign Pass  = pass_q;
  assign Error = error_q;
`ifdef CRC_CHK_SYNDROME_EN
  assign Syndrome = syn_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_checker.sv
// ============================================================================
//  Module   : tb_crc_checker
//  Purpose  : Self-checking bench for crc_checker. Frames are described at the
//             message level; the expected verdict, syndrome and Done edge are
//             derived from the CRC of the message and the bits actually sent.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_checker;

  localparam logic [7:0] POLY = 8'h44;
  localparam logic [7:0] SEED = 8'hD8;

  logic clk = 1'b0;
  logic rst, data, active, crc_valid;
  logic done, pass, error;
`ifdef CRC_CHK_SYNDROME_EN
  logic [7:0] syndrome;
`endif

  crc_checker #(.CRC_WD(8), .POLY(POLY), .SEED(SEED)) dut (
    .CLK       (clk),
    .RST       (rst),
    .DATA      (data),
    .Active    (active),
    .CRC_Valid (crc_valid),
    .Done      (done),
    .Pass      (pass),
    .Error     (error)
`ifdef CRC_CHK_SYNDROME_EN
    ,
    .Syndrome  (syndrome)
`endif
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         e;
    bit         pass;
    bit         err;
    logic [7:0] syn;
  } exp_t;

  exp_t       expq[$];
  bit         exp_pass = 1'b0;
  logic [7:0] exp_syn  = 8'h00;
  bit         run      = 1'b0;
  int         checks   = 0;
  int         errors   = 0;
  int         last_done_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // CRC of a message as the generator would produce it: LSB-first bits
  // through the Galois register, feedback mask = POLY taps plus the top bit.
  function automatic logic [7:0] crc_of(input logic [63:0] msg, input int len);
    logic [7:0] r;
    r = SEED;
    for (int i = 0; i < len; i++) begin
      if (msg[i] ^ r[0]) r = (r >> 1) ^ (8'h80 | (POLY & 8'h7F));
      else               r = r >> 1;
    end
    return r;
  endfunction

  // Per-cycle comparison against the expected event queue.
  always @(negedge clk) begin
    if (run && !rst) begin
      if (done) last_done_edge = edge_n;
      if (expq.size() > 0 && expq[0].e < edge_n) begin
        chk("missed_done", 32'd0, 32'd1);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].e == edge_n) begin
        chk("done", done, 1);
        chk("pass", pass, expq[0].pass);
        chk("error", error, expq[0].err);
        exp_pass = expq[0].pass;
        exp_syn  = expq[0].syn;
`ifdef CRC_CHK_SYNDROME_EN
        chk("syndrome", syndrome, exp_syn);
`endif
        void'(expq.pop_front());
      end else begin
        chk("done_quiet", done, 0);
        chk("error_quiet", error, 0);
        chk("pass_hold", pass, exp_pass);
`ifdef CRC_CHK_SYNDROME_EN
        chk("syndrome_hold", syndrome, exp_syn);
`endif
      end
    end
  end

  task automatic step(input bit a, input bit v, input bit d);
    active    = a;
    crc_valid = v;
    data      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    expq.delete();
    exp_pass = 1'b0;
    exp_syn  = 8'h00;
    rst = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] msg, input int len, input bit noisy);
    for (int i = 0; i < len; i++) step(1'b1, noisy ? 1'($urandom) : 1'b0, msg[i]);
    // First cycle with Active low still belongs to the data phase.
    step(1'b0, noisy ? 1'($urandom) : 1'b0, 1'($urandom));
  endtask

  // Full frame: message, then 8 CRC bits with an optional fixed gap before
  // bit gap_at and optional random gaps. Ends after the REPORT cycle.
  task automatic send_frame(input logic [63:0] msg, input int len, input logic [7:0] rx,
                            input int gap_at, input int gap_len, input bit noisy);
    logic [7:0] syn;
    syn = rx ^ crc_of(msg, len);
    send_data(msg, len, noisy);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) repeat (gap_len) step(1'b0, 1'b0, 1'($urandom));
      if (noisy) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom));
      step(1'b0, 1'b1, rx[k]);
    end
    expq.push_back('{e: edge_n, pass: (syn == 8'h00), err: 1'b0, syn: syn});
    step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic abort_frame(input logic [63:0] msg, input int len, input int nbits);
    logic [7:0] c;
    c = crc_of(msg, len);
    send_data(msg, len, 1'b0);
    for (int k = 0; k < nbits; k++) step(1'b0, 1'b1, c[k]);
    step(1'b1, 1'($urandom), 1'($urandom));
    expq.push_back('{e: edge_n, pass: 1'b0, err: 1'b1, syn: 8'h00});
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int s1, d1, s3, d3;
    logic [63:0] msg;
    logic [7:0]  rx;
    int          len;

    active = 1'b0; crc_valid = 1'b0; data = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    run = 1'b1;

    // Reset state.
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_error", error, 0);
`ifdef CRC_CHK_SYNDROME_EN
    chk("reset_syndrome", syndrome, 8'h00);
`endif
    chk("model_crc_00", crc_of(64'h0, 8), 8'h14);
    idle(2);

    // T1: good frame.
    s1 = edge_n;
    send_frame(64'h0, 8, 8'h14, -1, 0, 1'b0);
    d1 = last_done_edge - s1;
    chk("t1_pass", pass, 1);
    chk("t1_done_latency", d1, 17);
    idle(1);

    // T2: CRC bit 0 flipped.
    send_frame(64'h0, 8, 8'h15, -1, 0, 1'b0);
    chk("t2_pass", pass, 0);
`ifdef CRC_CHK_SYNDROME_EN
    chk("t2_syndrome", syndrome, 8'h01);
`endif
    idle(1);

    // T3: 3-cycle CRC_Valid gap after bit 3.
    s3 = edge_n;
    send_frame(64'h0, 8, 8'h14, 4, 3, 1'b0);
    d3 = last_done_edge - s3;
    chk("t3_pass", pass, 1);
    chk("t3_delay", d3 - d1, 3);
    idle(1);

    // T4: abort after 4 CRC bits.
    abort_frame(64'h0, 8, 4);
    chk("t4_pass_after_abort", pass, 0);
    idle(1);

    // T5: reset after 5 CRC bits, then a good frame.
    send_data(64'h0, 8, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, rx_bit(k));
    do_reset();
    send_frame(64'h0, 8, 8'h14, -1, 0, 1'b0);
    chk("t5_pass", pass, 1);
    idle(1);

    // T6: 10 generator frames, one idle cycle apart (the REPORT cycle).
    for (int f = 0; f < 10; f++) begin
      msg = {$urandom, $urandom};
      send_frame(msg, 8, crc_of(msg, 8), -1, 0, 1'b0);
    end
    idle(1);

    // Randomized frames: lengths, gaps, corruption, aborts, noise on ignored inputs.
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 40);
      msg = {$urandom, $urandom};
      rx  = crc_of(msg, len);
      if ($urandom_range(0, 3) == 0) rx = rx ^ 8'($urandom);
      if ($urandom_range(0, 9) == 0) abort_frame(msg, len, $urandom_range(0, 7));
      else send_frame(msg, len, rx, -1, 0, 1'b1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic bit rx_bit(input int k);
    logic [7:0] c;
    c = 8'h14;
    return c[k];
  endfunction

endmodule

`default_nettype wire
